// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator on the 8-bit CSR bus.
// One shared prescaler and period counter drive NUM_CH outputs. PERIOD and
// DUTY are staged and copied to their active registers only at period wrap,
// so updates take effect without glitching the outputs.
module pwm_multi #(
  parameter logic [4:0]  BASE_ADDR  = 5'h0,
  parameter int unsigned NUM_CH     = 2,
  parameter logic [7:0]  DFL_PERIOD = 8'hff
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        csr_a,
  input  logic [7:0]        csr_di,
  input  logic              csr_we,
  output logic [7:0]        csr_do,
  input  logic              pwm_ce,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_en
);

  localparam int unsigned DW   = 8;
  localparam int unsigned OFFW = 6;

  logic [NUM_CH-1:0] ctrl;
  logic [NUM_CH-1:0] pol;
  logic [DW-1:0]     prescale;
  logic [DW-1:0]     period_stg;
  logic [DW-1:0]     period_act;
  logic [DW-1:0]     duty_stg [NUM_CH];
  logic [DW-1:0]     duty_act [NUM_CH];
  logic [DW-1:0]     cnt;
  logic [DW-1:0]     presc_cnt;

  logic [OFFW-1:0]   off;
  logic              in_range;
  logic              wr_en;
  logic              running;
  logic              tick;
  logic              wrap;
  logic              load;

  // Address decode: the extra top bit catches addresses below BASE_ADDR as a borrow.
  assign off      = {1'b0, csr_a} - {1'b0, BASE_ADDR};
  assign in_range = (off < OFFW'(4 + NUM_CH));
  assign wr_en    = csr_we && in_range;

  assign running = |ctrl;
  assign tick    = running && pwm_ce && (presc_cnt == prescale);
  assign wrap    = (cnt == period_act);
  assign load    = tick && wrap;

  // CSR write path: direct registers and staging registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      pol        <= '0;
      prescale   <= '0;
      period_stg <= DFL_PERIOD;
      for (int i = 0; i < int'(NUM_CH); i++) duty_stg[i] <= '0;
    end else if (wr_en) begin
      case (off)
        OFFW'(0): ctrl       <= csr_di[NUM_CH-1:0];
        OFFW'(1): prescale   <= csr_di;
        OFFW'(2): period_stg <= csr_di;
        OFFW'(3): pol        <= csr_di[NUM_CH-1:0];
        default: begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (off == OFFW'(4 + i)) duty_stg[i] <= csr_di;
          end
        end
      endcase
    end
  end

  // CSR read mux; unmapped offsets and out-of-range addresses return zero.
  always_comb begin
    csr_do = '0;
    if (in_range) begin
      case (off)
        OFFW'(0): csr_do = DW'(ctrl);
        OFFW'(1): csr_do = prescale;
        OFFW'(2): csr_do = period_stg;
        OFFW'(3): csr_do = DW'(pol);
        default: begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (off == OFFW'(4 + i)) csr_do = duty_stg[i];
          end
        end
      endcase
    end
  end

  // Active registers: transparent while idle, otherwise loaded at period wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_act <= DFL_PERIOD;
      for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] <= '0;
    end else if (!running || load) begin
      period_act <= period_stg;
      for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] <= duty_stg[i];
    end
  end

  // Prescaler and period counter; both held at zero while idle.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else if (pwm_ce) begin
      if (presc_cnt == prescale) begin
        presc_cnt <= '0;
        cnt       <= wrap ? '0 : cnt + DW'(1);
      end else begin
        presc_cnt <= presc_cnt + DW'(1);
      end
    end
  end

  // Registered channel outputs; a disabled channel sits at its inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
      pwm_en  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        pwm_out[i] <= ctrl[i] ? ((cnt < duty_act[i]) ^ pol[i]) : pol[i];
      end
      pwm_en <= ctrl;
    end
  end

endmodule
